// File: rtl/gpi_conditioner.sv
// Board-input conditioner: per-channel synchroniser, optional inversion, stability-counter
// debounce, registered rise/fall pulses and sticky event flags with per-bit clear.
module gpi_conditioner #(
    parameter int unsigned      NumIn          = 8,
    parameter int unsigned      SyncStages     = 2,
    parameter int unsigned      DebounceCycles = 50000,
    parameter logic [NumIn-1:0] InvertMask     = '0,
    parameter logic [NumIn-1:0] ResetValue     = '0,
    parameter int unsigned      EvtEdge        = 0
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [NumIn-1:0] raw_i,
    input  logic [NumIn-1:0] evt_clr_i,
    output logic [NumIn-1:0] level_o,
    output logic [NumIn-1:0] rise_o,
    output logic [NumIn-1:0] fall_o,
    output logic [NumIn-1:0] evt_o
);

    localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    for (genvar gi = 0; gi < NumIn; gi++) begin : g_ch
        // Flops sit at the pre-inversion image of the reset level so no edge follows reset.
        localparam logic SyncRst = ResetValue[gi] ^ InvertMask[gi];

        logic [SyncStages-1:0] r_sync;
        logic [CntW-1:0]       r_cnt;
        logic                  r_stable;
        logic                  r_rise;
        logic                  r_fall;
        logic                  r_evt;
        logic                  w_s;
        logic                  w_accept;
        logic                  w_rise_nxt;
        logic                  w_fall_nxt;
        logic                  w_q;

        assign w_s        = r_sync[SyncStages-1] ^ InvertMask[gi];
        assign w_accept   = (w_s != r_stable) && (r_cnt == CntMax);
        assign w_rise_nxt = w_accept & w_s;
        assign w_fall_nxt = w_accept & ~w_s;

        if (EvtEdge == 0) begin : g_evt_rise
            assign w_q = w_rise_nxt;
        end else if (EvtEdge == 1) begin : g_evt_fall
            assign w_q = w_fall_nxt;
        end else begin : g_evt_both
            assign w_q = w_rise_nxt | w_fall_nxt;
        end

        always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
                r_sync <= {SyncStages{SyncRst}};
            end else begin
                r_sync <= {r_sync[SyncStages-2:0], raw_i[gi]};
            end
        end

        // Any cycle agreeing with the accepted level restarts the count (bounce rejection).
        always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
                r_stable <= ResetValue[gi];
                r_cnt    <= '0;
            end else if (w_s == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= w_s;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end

        // Set wins over a simultaneous clear.
        always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
            if (!rst_sys_ni) begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                r_evt  <= 1'b0;
            end else begin
                r_rise <= w_rise_nxt;
                r_fall <= w_fall_nxt;
                r_evt  <= (r_evt & ~evt_clr_i[gi]) | w_q;
            end
        end

        assign level_o[gi] = r_stable;
        assign rise_o[gi]  = r_rise;
        assign fall_o[gi]  = r_fall;
        assign evt_o[gi]   = r_evt;
    end

endmodule

// File: tb/tb_gpi_conditioner.sv
// Bench for gpi_conditioner: two instances (plain/both-edge and ch0-inverted/rise-only) share
// stimulus; a history-window reference model feeds a scoreboard, plus directed latency checks.
module tb_gpi_conditioner;

    typedef struct packed {
        logic [7:0] lvl;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] evt;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] raw_i = 8'h00;
    logic [7:0] evt_clr_i = 8'h00;
    logic [7:0] level0, rise0, fall0, evt0;
    logic [7:0] level1, rise1, fall1, evt1;

    int n_checks = 0;
    int n_errors = 0;
    int n_edges  = 0;

    pair_t q_exp[$];

    logic [7:0] m_s0[2];
    logic [7:0] m_s1[2];
    logic [7:0] m_hist[2][4];
    logic [7:0] m_lvl[2];
    logic [7:0] m_rise[2];
    logic [7:0] m_fall[2];
    logic [7:0] m_evt[2];

    always #5 clk = ~clk;

    gpi_conditioner #(
        .NumIn(8), .SyncStages(2), .DebounceCycles(4),
        .InvertMask(8'h00), .ResetValue(8'h00), .EvtEdge(2)
    ) u_dut0 (
        .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(raw_i), .evt_clr_i(evt_clr_i),
        .level_o(level0), .rise_o(rise0), .fall_o(fall0), .evt_o(evt0)
    );

    gpi_conditioner #(
        .NumIn(8), .SyncStages(2), .DebounceCycles(4),
        .InvertMask(8'h01), .ResetValue(8'h00), .EvtEdge(0)
    ) u_dut1 (
        .clk_sys_i(clk), .rst_sys_ni(rst_n), .raw_i(raw_i), .evt_clr_i(evt_clr_i),
        .level_o(level1), .rise_o(rise1), .fall_o(fall1), .evt_o(evt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] inv_of(input int d);
        return (d == 1) ? 8'h01 : 8'h00;
    endfunction

    // A channel accepts when its last four synchronised samples all differ from the level.
    task automatic model_edge(input logic [7:0] raw, input logic [7:0] clr, input logic rstn);
        logic [7:0] s, acc, q;
        for (int d = 0; d < 2; d++) begin
            if (!rstn) begin
                m_s0[d] = inv_of(d);
                m_s1[d] = inv_of(d);
                for (int k = 0; k < 4; k++) m_hist[d][k] = 8'h00;
                m_lvl[d]  = 8'h00;
                m_rise[d] = 8'h00;
                m_fall[d] = 8'h00;
                m_evt[d]  = 8'h00;
            end else begin
                s = m_s1[d] ^ inv_of(d);
                for (int k = 3; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
                m_hist[d][0] = s;
                acc = 8'hff;
                for (int k = 0; k < 4; k++) acc = acc & (m_hist[d][k] ^ m_lvl[d]);
                m_rise[d] = acc & s;
                m_fall[d] = acc & ~s;
                q = (d == 0) ? (m_rise[d] | m_fall[d]) : m_rise[d];
                m_evt[d] = (m_evt[d] & ~clr) | q;
                m_lvl[d] = m_lvl[d] ^ acc;
                m_s1[d] = m_s0[d];
                m_s0[d] = raw;
            end
        end
    endtask

    task automatic step(input logic [7:0] raw, input logic [7:0] clr, input logic rstn);
        pair_t e;
        raw_i     = raw;
        evt_clr_i = clr;
        rst_n     = rstn;
        model_edge(raw, clr, rstn);
        e.a = '{m_lvl[0], m_rise[0], m_fall[0], m_evt[0]};
        e.b = '{m_lvl[1], m_rise[1], m_fall[1], m_evt[1]};
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        n_edges++;
        e = q_exp.pop_front();
        check($sformatf("d0_level@%0d", n_edges), {24'h0, level0}, {24'h0, e.a.lvl});
        check($sformatf("d0_rise@%0d", n_edges),  {24'h0, rise0},  {24'h0, e.a.rise});
        check($sformatf("d0_fall@%0d", n_edges),  {24'h0, fall0},  {24'h0, e.a.fall});
        check($sformatf("d0_evt@%0d", n_edges),   {24'h0, evt0},   {24'h0, e.a.evt});
        check($sformatf("d1_level@%0d", n_edges), {24'h0, level1}, {24'h0, e.b.lvl});
        check($sformatf("d1_rise@%0d", n_edges),  {24'h0, rise1},  {24'h0, e.b.rise});
        check($sformatf("d1_fall@%0d", n_edges),  {24'h0, fall1},  {24'h0, e.b.fall});
        check($sformatf("d1_evt@%0d", n_edges),   {24'h0, evt1},   {24'h0, e.b.evt});
    endtask

    initial begin
        int e0;
        logic [7:0] acc;
        logic [7:0] r;

        model_edge(8'h00, 8'h00, 1'b0);

        // Reset, then idle with all inputs low
        for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0);
        acc = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step(8'h00, 8'h00, 1'b1);
            acc = acc | level0 | rise0 | fall0 | evt0;
        end
        check("idle_quiet", {24'h0, acc}, 32'h0);

        // Rising change on ch0
        e0 = n_edges;
        do step(8'h01, 8'h00, 1'b1); while (!rise0[0] && (n_edges - e0) < 20);
        check("rise0_latency", n_edges - e0, 6);
        check("rise0_level", {31'h0, level0[0]}, 32'h1);
        check("rise0_evt", {31'h0, evt0[0]}, 32'h1);
        step(8'h01, 8'h00, 1'b1);
        check("rise0_one_cycle", {31'h0, rise0[0]}, 32'h0);
        check("rise0_evt_sticky", {31'h0, evt0[0]}, 32'h1);

        // Bounce on ch3 must be rejected
        acc = 8'h00;
        for (int i = 0; i < 3; i++) begin step(8'h09, 8'h00, 1'b1); acc |= level0 | rise0 | evt0; end
        step(8'h01, 8'h00, 1'b1); acc |= level0 | rise0 | evt0;
        for (int i = 0; i < 3; i++) begin step(8'h09, 8'h00, 1'b1); acc |= level0 | rise0 | evt0; end
        for (int i = 0; i < 8; i++) begin step(8'h01, 8'h00, 1'b1); acc |= level0 | rise0 | evt0; end
        check("bounce3_quiet", {31'h0, acc[3]}, 32'h0);

        // Clear ch0 event, then falling change
        step(8'h01, 8'h01, 1'b1);
        check("clr0_evt", {31'h0, evt0[0]}, 32'h0);
        e0 = n_edges;
        do step(8'h00, 8'h00, 1'b1); while (!fall0[0] && (n_edges - e0) < 20);
        check("fall0_latency", n_edges - e0, 6);
        check("fall0_evt_both", {31'h0, evt0[0]}, 32'h1);
        check("fall0_level", {31'h0, level0[0]}, 32'h0);

        // Clear held across the qualifying pulse on ch1
        e0 = n_edges;
        do step(8'h02, 8'h02, 1'b1); while (!rise0[1] && (n_edges - e0) < 20);
        check("rise1_latency", n_edges - e0, 6);
        check("rise1_evt_set_wins", {31'h0, evt0[1]}, 32'h1);
        step(8'h02, 8'h02, 1'b1);
        check("rise1_evt_cleared", {31'h0, evt0[1]}, 32'h0);

        // Inverted ch0 held high through reset on instance 1
        for (int i = 0; i < 2; i++) step(8'h03, 8'h00, 1'b0);
        acc = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step(8'h03, 8'h00, 1'b1);
            acc = acc | level1 | rise1 | fall1;
        end
        check("inv0_quiet", {31'h0, acc[0]}, 32'h0);
        e0 = n_edges;
        do step(8'h02, 8'h00, 1'b1); while (!rise1[0] && (n_edges - e0) < 20);
        check("inv0_rise_latency", n_edges - e0, 6);
        check("inv0_evt_rise", {31'h0, evt1[0]}, 32'h1);

        // Reset part-way through a debounce discards the partial count
        for (int i = 0; i < 4; i++) step(8'h06, 8'h00, 1'b1);
        step(8'h06, 8'h00, 1'b0);
        check("midreset_level2", {31'h0, level0[2]}, 32'h0);
        e0 = n_edges;
        do step(8'h06, 8'h00, 1'b1); while (!rise0[2] && (n_edges - e0) < 20);
        check("midreset_latency", n_edges - e0, 6);

        // Random slow-changing traffic with random clears
        r = 8'h06;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
            step(r, 8'($urandom) & 8'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
